// File: rtl/rx_pkg.sv
// Shared types and constants for the UART receive path.
package rx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int unsigned MIN_BIT_PERIOD = 4;

endpackage

// File: rtl/rx_bit_timer.sv
// Down-counting bit timer: tick fires exactly N clocks after a load of N.
module rx_bit_timer #(
  parameter int PERIOD_W = 14
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                load,
  input  logic                en,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Reload on tick is driven by the owner through load, keeping this block policy-free.
  assign tick = en && (count == PERIOD_W'(1));

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame sequencer: start detect, mid-bit shift strobes, stop check and status flags.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PERIOD_W  = 14
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                serial_in,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic                data_read,
  output logic                shift_enable,
  output logic                load_buffer,
  output logic                data_ready,
  output logic                framing_error,
  output logic                overrun_error,
  output logic                busy
);

  localparam int CNT_W = 5;

  rx_state_t           state, state_nx;
  logic                prev_in;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] per_in;
  logic                per_cap;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nx;
  logic                timer_load;
  logic [PERIOD_W-1:0] timer_val;
  logic                tick;
  logic                frame_err_set;

  assign per_in = (bit_period < PERIOD_W'(MIN_BIT_PERIOD)) ? PERIOD_W'(MIN_BIT_PERIOD)
                                                           : bit_period;
  assign busy   = (state != IDLE);

  rx_bit_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .load_val (timer_val),
    .load     (timer_load),
    .en       (busy),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      prev_in <= 1'b1;
      bit_cnt <= '0;
      per_q   <= PERIOD_W'(MIN_BIT_PERIOD);
    end else begin
      state   <= state_nx;
      prev_in <= serial_in;
      bit_cnt <= bit_cnt_nx;
      if (per_cap) per_q <= per_in;
    end
  end

  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    timer_load    = 1'b0;
    timer_val     = per_q;
    per_cap       = 1'b0;
    shift_enable  = 1'b0;
    load_buffer   = 1'b0;
    frame_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (prev_in && !serial_in) begin
          state_nx   = START;
          timer_load = 1'b1;
          timer_val  = per_in >> 1;
          per_cap    = 1'b1;
          bit_cnt_nx = '0;
        end
      end
      START: begin
        if (tick) begin
          if (!serial_in) begin
            state_nx   = DATA;
            timer_load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_enable = 1'b1;
          timer_load   = 1'b1;
          bit_cnt_nx   = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_BITS - 1)) state_nx = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (serial_in) load_buffer   = 1'b1;
          else           frame_err_set = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Set events take priority over the data_read clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (load_buffer)    data_ready <= 1'b1;
      else if (data_read) data_ready <= 1'b0;

      if (load_buffer && data_ready && !data_read) overrun_error <= 1'b1;
      else if (data_read)                          overrun_error <= 1'b0;

      if (frame_err_set)  framing_error <= 1'b1;
      else if (data_read) framing_error <= 1'b0;
    end
  end

endmodule
